rah_hash_tx_framer: RTL and testbench

RAH_HASH_TX_FRAMER -- requirements
Module: rah_hash_tx_framer

---
 rtl/rah_hash_tx_framer.sv | 172 +++++++++++++++++
 tb/tb_rah_hash_tx_framer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rah_hash_tx_framer.sv
// rtl/rah_hash_tx_framer.sv - frames hash payload words into RAH transmit packets
//
// Buffers payload words from the hash bridge in a FIFO. Once a full frame's
// worth is buffered, it sends a header word, then WORDS_PER_FRAME payload
// words. When the macro RAH_TX_CHECKSUM_EN is defined, it also sends an XOR
// checksum trailer word.
//
// Ports:
//   clk        - single clock
//   rst        - synchronous active-high reset
//   send_data  - strobe qualifying wrdata
//   wrdata     - payload word [DATA_WIDTH]
//   tx_valid   - tx_data valid toward transmit link (registered)
//   tx_data    - framed output word [DATA_WIDTH] (registered)
//   tx_ready   - link accepts tx_data this cycle
//   overflow   - sticky, set when a word is dropped on a full FIFO
//   frame_seq  - sequence number of the next frame to be sent
//
// Optional feature macro: RAH_TX_CHECKSUM_EN (checksum trailer word)
module rah_hash_tx_framer #(
  parameter int         DATA_WIDTH      = 48,
  parameter int         WORDS_PER_FRAME = 6,
  parameter int         FIFO_DEPTH      = 16,
  parameter logic [7:0] APP_ID          = 8'h01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send_data,
  input  logic [DATA_WIDTH-1:0] wrdata,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_ready,
  output logic                  overflow,
  output logic [7:0]            frame_seq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int WC_W  = $clog2(WORDS_PER_FRAME + 1);

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(WORDS_PER_FRAME);
  localparam logic [WC_W-1:0]  WC_LAST   = WC_W'(WORDS_PER_FRAME - 1);

`ifdef RAH_TX_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_TRAILER} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_t;
`endif

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [WC_W-1:0]       word_cnt, word_cnt_n;
  logic                  tx_valid_n;
  logic [DATA_WIDTH-1:0] tx_data_n;
  logic                  push, pop, xfer, seq_inc;
`ifdef RAH_TX_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum, checksum_n;
`endif

  // Fullness uses the pre-edge count, so a word arriving on a full FIFO is
  // dropped even if a pop frees a slot on the same edge.
  assign push = send_data && (count < CNT_FULL);
  assign xfer = tx_valid && tx_ready;

  always_comb begin
    state_n    = state;
    tx_valid_n = tx_valid;
    tx_data_n  = tx_data;
    word_cnt_n = word_cnt;
    pop        = 1'b0;
    seq_inc    = 1'b0;
`ifdef RAH_TX_CHECKSUM_EN
    checksum_n = checksum;
`endif
    case (state)
      S_IDLE: begin
        if (count >= CNT_FRAME) begin
          state_n    = S_HEADER;
          tx_valid_n = 1'b1;
          tx_data_n  = DATA_WIDTH'({8'hA5, APP_ID, frame_seq,
                                    8'(WORDS_PER_FRAME), 16'h0000});
`ifdef RAH_TX_CHECKSUM_EN
          checksum_n = '0;
`endif
        end
      end
      S_HEADER: begin
        // A whole frame is already buffered, so the FIFO head is valid.
        if (xfer) begin
          state_n    = S_PAYLOAD;
          tx_data_n  = mem[rd_ptr];
          word_cnt_n = '0;
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          pop = 1'b1;
`ifdef RAH_TX_CHECKSUM_EN
          checksum_n = checksum ^ tx_data;
`endif
          if (word_cnt == WC_LAST) begin
`ifdef RAH_TX_CHECKSUM_EN
            state_n   = S_TRAILER;
            tx_data_n = checksum ^ tx_data;
`else
            state_n    = S_IDLE;
            tx_valid_n = 1'b0;
            seq_inc    = 1'b1;
`endif
          end else begin
            // Prefetch the word behind the one being popped.
            word_cnt_n = word_cnt + 1'b1;
            tx_data_n  = mem[rd_ptr + 1'b1];
          end
        end
      end
`ifdef RAH_TX_CHECKSUM_EN
      S_TRAILER: begin
        if (xfer) begin
          state_n    = S_IDLE;
          tx_valid_n = 1'b0;
          seq_inc    = 1'b1;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      word_cnt  <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      overflow  <= 1'b0;
      frame_seq <= 8'h00;
`ifdef RAH_TX_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      state    <= state_n;
      word_cnt <= word_cnt_n;
      tx_valid <= tx_valid_n;
      tx_data  <= tx_data_n;
`ifdef RAH_TX_CHECKSUM_EN
      checksum <= checksum_n;
`endif
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (send_data && !push) overflow <= 1'b1;
      if (seq_inc) frame_seq <= frame_seq + 8'h01;
    end
  end

  // Storage array carries no reset; pointers define its valid region.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= wrdata;
  end

endmodule

// File: tb/tb_rah_hash_tx_framer.sv
// tb/tb_rah_hash_tx_framer.sv - self-checking bench for rah_hash_tx_framer
module tb_rah_hash_tx_framer;

  localparam int DW  = 48;
  localparam int WPF = 6;
`ifdef RAH_TX_CHECKSUM_EN
  localparam int FRAME_LEN = WPF + 2;
`else
  localparam int FRAME_LEN = WPF + 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          send_data;
  logic [DW-1:0] wrdata;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic          overflow;
  logic [7:0]    frame_seq;

  always #5 clk = ~clk;

  rah_hash_tx_framer #(
    .DATA_WIDTH(DW), .WORDS_PER_FRAME(WPF), .FIFO_DEPTH(16), .APP_ID(8'h01)
  ) dut (
    .clk(clk), .rst(rst), .send_data(send_data), .wrdata(wrdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .overflow(overflow), .frame_seq(frame_seq)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pend_q[$];
  logic [7:0]    mseq = 8'h00;
  int            xfers = 0;
  int            mark = 0;
  int            low_cnt = 0;
  int            rmode = 1;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: a frame is queued once WPF accepted words are pending.
  function automatic void model_push(logic [DW-1:0] w);
    logic [DW-1:0] chk;
    logic [DW-1:0] p;
    pend_q.push_back(w);
    if (pend_q.size() == WPF) begin
      exp_q.push_back({8'hA5, 8'h01, mseq, 8'(WPF), 16'h0000});
      chk = '0;
      for (int i = 0; i < WPF; i++) begin
        p = pend_q.pop_front();
        chk ^= p;
        exp_q.push_back(p);
      end
`ifdef RAH_TX_CHECKSUM_EN
      exp_q.push_back(chk);
`endif
      mseq = mseq + 8'h01;
    end
  endfunction

  // Link-side monitor: scoreboard compare on transfer plus stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(tx_valid), 64'd1);
        check("stall_data", 64'(tx_data), 64'(prev_data));
      end
      if (!tx_valid && xfers > mark && xfers < mark + 2 * FRAME_LEN) low_cnt++;
      if (tx_valid && tx_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", tx_data);
        end else begin
          check("tx_word", 64'(tx_data), 64'(exp_q.pop_front()));
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  // tx_ready pattern: 0 hold low, 1 hold high, 2 toggle, 3 random.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       tx_ready = 1'b0;
      1:       tx_ready = 1'b1;
      2:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    send_data = 1'b0;
    idle(2);
    rst = 1'b0;
    exp_q.delete();
    pend_q.delete();
    mseq = 8'h00;
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_frame_seq", 64'(frame_seq), 64'd0);
  endtask

  task automatic send(input logic [DW-1:0] w, input bit accept);
    send_data = 1'b1;
    wrdata    = w;
    idle(1);
    send_data = 1'b0;
    if (accept) model_push(w);
  endtask

  task automatic drain();
    int t;
    rmode = 1;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      idle(1);
      t++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    idle(3);
    check("idle_tx_valid", 64'(tx_valid), 64'd0);
  endtask

  typedef struct {
    int            nwords;
    int            mode;
    logic [DW-1:0] base;
    int            n_accept;
    logic          exp_ovf;
    logic [7:0]    exp_seq;
    int            exp_gap;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    send_data = 1'b0;
    wrdata = '0;
    tx_ready = 1'b0;

    vecs[0] = '{6,  1, 48'h1,             6,  1'b0, 8'd1, -1};
    vecs[1] = '{6,  2, 48'h1,             6,  1'b0, 8'd1, -1};
    vecs[2] = '{12, 1, 48'h100,           12, 1'b0, 8'd2,  1};
    vecs[3] = '{17, 0, 48'h1,             16, 1'b1, 8'd2, -1};
    vecs[4] = '{12, 3, 48'h5A5A_0000_0000, 12, 1'b0, 8'd2, -1};

    for (int v = 0; v < 5; v++) begin
      do_reset();
      rmode = vecs[v].mode;
      mark = xfers;
      low_cnt = 0;
      for (int i = 0; i < vecs[v].nwords; i++) begin
        send(vecs[v].base + DW'(i), i < vecs[v].n_accept);
        check("overflow_flag", 64'(overflow), 64'(i >= vecs[v].n_accept));
      end
      drain();
      check("frame_seq_end", 64'(frame_seq), 64'(vecs[v].exp_seq));
      if (vecs[v].exp_gap >= 0) check("frame_gap", 64'(low_cnt), 64'(vecs[v].exp_gap));
    end

    // Reset after header plus three payload words discards the frame.
    do_reset();
    rmode = 1;
    mark = xfers;
    for (int i = 1; i <= 6; i++) send(48'hC0 + DW'(i), 1'b1);
    for (int t = 0; t < 50; t++) begin
      if (xfers >= mark + 4) break;
      idle(1);
    end
    check("midframe_reached", 64'(xfers - mark), 64'd4);
    rst = 1'b1;
    idle(1);
    check("midrst_tx_valid", 64'(tx_valid), 64'd0);
    check("midrst_frame_seq", 64'(frame_seq), 64'd0);
    check("midrst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    pend_q.delete();
    mseq = 8'h00;
    for (int i = 1; i <= 6; i++) send(48'hD0 + DW'(i), 1'b1);
    drain();
    check("midrst_seq_after", 64'(frame_seq), 64'd1);

    // Sequence number wrap over 256 frames, then a 257th frame with seq 00.
    do_reset();
    rmode = 1;
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < WPF; i++) send(DW'(f * 16 + i), 1'b1);
      idle(4);
    end
    drain();
    check("seq_wrap", 64'(frame_seq), 64'd0);
    for (int i = 0; i < WPF; i++) send(48'hF00 + DW'(i), 1'b1);
    drain();
    check("seq_after_wrap", 64'(frame_seq), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
